// File: rtl/shift_arbiter_if.sv
// Request/result bundle between the ALU issue logic and the shared shifter.
// master = requesters plus result consumer; slave = shift_arbiter.
interface shift_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 32
);
  localparam int unsigned IdW = $clog2(NUM_REQ);
  localparam int unsigned SaW = $clog2(WIDTH);

  logic [NUM_REQ-1:0]       ctrl_req;
  logic [NUM_REQ*WIDTH-1:0] data_operandA;
  logic [NUM_REQ*SaW-1:0]   ctrl_shiftamt;
  logic [NUM_REQ-1:0]       ctrl_op;
  logic [NUM_REQ-1:0]       ctrl_grant;
  logic [WIDTH-1:0]         data_result;
  logic [IdW-1:0]           ctrl_result_id;
  logic                     ctrl_result_valid;
  logic                     ctrl_result_ready;

  modport master (
    output ctrl_req, data_operandA, ctrl_shiftamt, ctrl_op, ctrl_result_ready,
    input  ctrl_grant, data_result, ctrl_result_id, ctrl_result_valid
  );

  modport slave (
    input  ctrl_req, data_operandA, ctrl_shiftamt, ctrl_op, ctrl_result_ready,
    output ctrl_grant, data_result, ctrl_result_id, ctrl_result_valid
  );
endinterface

// File: rtl/shift_arbiter.sv
// Round-robin arbiter in front of one shared barrel shifter with a single result register.
// Optional: define SHIFT_ARB_SRA_EN to build the arithmetic-right-shift path (ctrl_op = 1).
module shift_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 32
) (
  input  logic           clock,
  input  logic           reset,
  shift_arbiter_if.slave bus
);
  localparam int unsigned IdW = $clog2(NUM_REQ);
  localparam int unsigned SaW = $clog2(WIDTH);

  typedef enum logic [0:0] {StEmpty, StFull} state_e;

  state_e           state_q;
  logic [IdW-1:0]   last_q;
  logic [IdW-1:0]   id_q;
  logic [WIDTH-1:0] result_q;

  logic             accept;
  logic             found;
  logic [IdW-1:0]   cand;
  logic [IdW-1:0]   win_idx;
  logic [WIDTH-1:0] sel_a;
  logic [SaW-1:0]   sel_s;
  logic             sel_op;
  logic [WIDTH-1:0] sll_res;
  logic [WIDTH-1:0] shifted;

  assign accept = (|bus.ctrl_req) && ((state_q == StEmpty) || bus.ctrl_result_ready);

  // Scan last+1 .. last+NUM_REQ; the wrap makes the previous winner lowest priority.
  always_comb begin
    found   = 1'b0;
    cand    = last_q;
    win_idx = last_q;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = last_q + IdW'(k);
      if (!found && bus.ctrl_req[cand]) begin
        found   = 1'b1;
        win_idx = cand;
      end
    end
  end

  always_comb begin
    sel_a  = '0;
    sel_s  = '0;
    sel_op = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (win_idx == IdW'(i)) begin
        sel_a  = bus.data_operandA[i*WIDTH +: WIDTH];
        sel_s  = bus.ctrl_shiftamt[i*SaW +: SaW];
        sel_op = bus.ctrl_op[i];
      end
    end
  end

  assign sll_res = sel_a << sel_s;

`ifdef SHIFT_ARB_SRA_EN
  logic signed [WIDTH-1:0] sra_res;
  assign sra_res = $signed(sel_a) >>> sel_s;
  assign shifted = sel_op ? unsigned'(sra_res) : sll_res;
`else
  logic unused_op;
  assign unused_op = sel_op;
  assign shifted   = sll_res;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= StEmpty;
      last_q   <= IdW'(NUM_REQ - 1);
      id_q     <= '0;
      result_q <= '0;
    end else if (accept) begin
      state_q  <= StFull;
      last_q   <= win_idx;
      id_q     <= win_idx;
      result_q <= shifted;
    end else if ((state_q == StFull) && bus.ctrl_result_ready) begin
      state_q  <= StEmpty;
    end
  end

  assign bus.ctrl_grant        = accept ? (NUM_REQ'(1) << win_idx) : '0;
  assign bus.data_result       = result_q;
  assign bus.ctrl_result_id    = id_q;
  assign bus.ctrl_result_valid = (state_q == StFull);
endmodule
